fetch_pc_stage: RTL and testbench
=================================

Name: fetch_pc_stage

Overview:
- Instruction-fetch stage directly upstream of the branch-target adder.
- Holds the program counter and issues one word fetch at a time to instruction memory.
- Registers each fetched instruction with its PC+4 into the IF/ID slot. IfIdPcPlus4 is the base operand of the branch-target adder.
- Accepts the adder's result back as a redirect target when a branch resolves taken.

Parameters:
- RESET_PC, 32'h0000_0000: PC loaded on reset.
- PC_STEP, 4: sequential increment in bytes.

Ports:
- Clk  in  1  system clock, rising edge.
- ResetN  in  1  asynchronous, active-low reset.
- BranchTaken  in  1  single-cycle redirect strobe from branch resolution.
- BranchTarget  in  32  redirect address (branch-target adder output).
- ImemReqValid  out  1  fetch request valid.
- ImemReqAddr  out  32  fetch address; held stable while ImemReqValid=1 and ImemReqReady=0.
- ImemReqReady  in  1  memory accepts request.
- ImemRspValid  in  1  response valid (one cycle per accepted request).
- ImemRspData  in  32  fetched instruction word.
- IfIdValid  out  1  IF/ID slot holds a valid instruction.
- IfIdInstr  out  32  registered instruction.
- IfIdPcPlus4  out  32  registered (fetch address + PC_STEP) mod 2^32.
- IfIdReady  in  1  decode consumes the IF/ID slot this cycle.
- TargetMisaligned  out  1  one-cycle pulse when a redirect target has BranchTarget[1:0] != 0.

Behaviour:
- Reset (async assert, sync-to-Clk release):
  - Pc=RESET_PC, state=IDLE, Drop=0.
  - ImemReqValid=0, ImemReqAddr=RESET_PC.
  - IfIdValid=0, IfIdInstr=0, IfIdPcPlus4=0, TargetMisaligned=0.
  - Skid buffer cleared.
- At most one request outstanding.
- IDLE:
  - Goes to REQ on the first clock after reset release.
  - ImemRspValid is ignored.
- REQ:
  - ImemReqValid=1, ImemReqAddr=Pc.
  - On ImemReqReady: Pc <= Pc+PC_STEP; record the fetch address; go to WAIT.
- WAIT, on ImemRspValid:
  - If Drop=1: discard the response, clear Drop, go to REQ.
  - Else, if IfIdValid=0 or IfIdReady=1: load IfIdInstr, IfIdPcPlus4 and IfIdValid=1; go to REQ. Next request is issued the following cycle, so sustained throughput is 1 instruction per 2 cycles minimum.
  - Else: capture into the skid buffer, go to HOLD.
- HOLD:
  - No request is issued.
  - On IfIdReady: move the skid buffer into IF/ID (IfIdValid stays 1); go to REQ.
- Drain without refill: IfIdValid=1, IfIdReady=1 and no load this cycle -> IfIdValid <= 0.
- BranchTaken: takes priority over all other events in the same cycle.
  - Pc <= {BranchTarget[31:2], 2'b00}.
  - TargetMisaligned pulses the next cycle if BranchTarget[1:0] != 0.
  - IfIdValid <= 0, regardless of IfIdReady.
  - IDLE: Pc updated; state goes to REQ as normal.
  - REQ without ImemReqReady: the request still completes at its original address (stability rule); Drop <= 1.
  - REQ with ImemReqReady the same cycle: the request is accepted; Pc takes the target, not Pc+4; Drop <= 1; go to WAIT.
  - WAIT without ImemRspValid: Drop <= 1.
  - WAIT with ImemRspValid the same cycle: the response is discarded; go to REQ; Drop stays 0.
  - HOLD: the skid buffer is discarded; go to REQ.
- Arithmetic:
  - Pc and IfIdPcPlus4 wrap modulo 2^32 (0xFFFF_FFFC + 4 = 0). No flag is raised.
  - Pc[1:0] is always 2'b00.
- Reset mid-operation: all state returns to reset values immediately. A stale ImemRspValid after release is ignored (IDLE, and REQ before acceptance).

Decomposition:
- Package cpu_pkg:
  - word_t (logic [31:0]).
  - fetch_state_e {IDLE, REQ, WAIT, HOLD}.
  - PC_STEP constant.
  - RESET_PC default constant.
- One natural sub-module, fetch_skid_buffer: a one-entry {instr, pcplus4} holding register with load/unload/flush controls, used for the HOLD path.

Test Plan:
- Basic fetch: release reset; ImemReqReady=1; response 0x2002_0005 one cycle after acceptance; IfIdReady=1.
  -> First ImemReqAddr=0x0, second =0x4.
  -> IfIdInstr=0x2002_0005, IfIdPcPlus4=0x4, IfIdValid=1.
- Backpressure: IfIdReady=0 with IF/ID full and a response arriving.
  -> Enters HOLD; ImemReqValid=0.
  -> When IfIdReady=1, the held word appears next and in order; fetch resumes at the next address.
- Redirect in WAIT: BranchTaken with BranchTarget=0x40; response 0xDEAD_BEEF arrives next cycle.
  -> That response is dropped and IfIdValid=0.
  -> Next ImemReqAddr=0x40; its instruction shows IfIdPcPlus4=0x44.
- Simultaneous branch and response: BranchTaken with ImemRspValid in the same cycle.
  -> Response discarded; next request at the target.
- Misaligned target: BranchTarget=0x43.
  -> ImemReqAddr=0x40; TargetMisaligned high for exactly one cycle.
- Wrap and reset: RESET_PC=0xFFFF_FFFC.
  -> Addresses 0xFFFF_FFFC, then 0x0; IfIdPcPlus4=0x0.
  -> ResetN low during WAIT clears all outputs immediately.
  -> A response pulse after release produces no IF/ID load.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package cpu_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

  localparam word_t DEFAULT_PC_STEP  = 32'd4;
  localparam word_t DEFAULT_RESET_PC = 32'h0000_0000;

  // Branch targets are forced onto a word boundary before they reach the PC.
  function automatic word_t word_align(input word_t addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for a fetched word that arrived while IF/ID was
// still occupied; drained into IF/ID once decode frees the slot.
module fetch_skid_buffer
  import cpu_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  load_i,
  input  logic  unload_i,
  input  logic  flush_i,
  input  word_t instr_i,
  input  word_t pcplus4_i,
  output logic  valid_o,
  output word_t instr_o,
  output word_t pcplus4_o
);

  logic  valid_q,   valid_d;
  word_t instr_q,   instr_d;
  word_t pcplus4_q, pcplus4_d;

  always_comb begin
    valid_d   = valid_q;
    instr_d   = instr_q;
    pcplus4_d = pcplus4_q;
    // A flush from a taken branch beats any same-cycle load.
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d   = 1'b1;
      instr_d   = instr_i;
      pcplus4_d = pcplus4_i;
    end else if (unload_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q   <= 1'b0;
      instr_q   <= '0;
      pcplus4_q <= '0;
    end else begin
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      pcplus4_q <= pcplus4_d;
    end
  end

  assign valid_o   = valid_q;
  assign instr_o   = instr_q;
  assign pcplus4_o = pcplus4_q;

endmodule

// File: rtl/fetch_pc_stage.sv
// Fetch stage: owns the PC, issues one instruction-memory request at a time and
// fills the IF/ID slot; taken branches redirect the PC and squash in-flight work.
module fetch_pc_stage
  import cpu_pkg::*;
#(
  parameter word_t RESET_PC = DEFAULT_RESET_PC,
  parameter word_t PC_STEP  = DEFAULT_PC_STEP
) (
  input  logic  Clk,
  input  logic  ResetN,
  input  logic  BranchTaken,
  input  word_t BranchTarget,
  output logic  ImemReqValid,
  output word_t ImemReqAddr,
  input  logic  ImemReqReady,
  input  logic  ImemRspValid,
  input  word_t ImemRspData,
  output logic  IfIdValid,
  output word_t IfIdInstr,
  output word_t IfIdPcPlus4,
  input  logic  IfIdReady,
  output logic  TargetMisaligned
);

  fetch_state_e state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        req_addr_q, req_addr_d;
  word_t        fetch_addr_q, fetch_addr_d;
  logic         drop_q, drop_d;
  logic         ifid_valid_q, ifid_valid_d;
  word_t        ifid_instr_q, ifid_instr_d;
  word_t        ifid_pcplus4_q, ifid_pcplus4_d;
  logic         misaligned_q, misaligned_d;

  logic         skid_load, skid_unload, skid_flush;
  logic         skid_valid;
  word_t        skid_instr, skid_pcplus4;
  word_t        rsp_pcplus4;

  assign rsp_pcplus4 = fetch_addr_q + PC_STEP;

  fetch_skid_buffer u_skid (
    .clk_i     (Clk),
    .rst_ni    (ResetN),
    .load_i    (skid_load),
    .unload_i  (skid_unload),
    .flush_i   (skid_flush),
    .instr_i   (ImemRspData),
    .pcplus4_i (rsp_pcplus4),
    .valid_o   (skid_valid),
    .instr_o   (skid_instr),
    .pcplus4_o (skid_pcplus4)
  );

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    fetch_addr_d   = fetch_addr_q;
    drop_d         = drop_q;
    ifid_valid_d   = ifid_valid_q;
    ifid_instr_d   = ifid_instr_q;
    ifid_pcplus4_d = ifid_pcplus4_q;
    misaligned_d   = 1'b0;
    skid_load      = 1'b0;
    skid_unload    = 1'b0;
    skid_flush     = 1'b0;

    if (ifid_valid_q && IfIdReady) begin
      ifid_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (ImemReqReady) begin
          fetch_addr_d = req_addr_q;
          // With Drop set the PC already holds the redirect target, which is
          // what must be fetched next, so it is not advanced.
          pc_d    = drop_q ? pc_q : pc_q + PC_STEP;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (ImemRspValid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = REQ;
          end else if (!ifid_valid_q || IfIdReady) begin
            ifid_valid_d   = 1'b1;
            ifid_instr_d   = ImemRspData;
            ifid_pcplus4_d = rsp_pcplus4;
            state_d        = REQ;
          end else begin
            skid_load = 1'b1;
            state_d   = HOLD;
          end
        end
      end
      HOLD: begin
        if (IfIdReady && skid_valid) begin
          ifid_valid_d   = 1'b1;
          ifid_instr_d   = skid_instr;
          ifid_pcplus4_d = skid_pcplus4;
          skid_unload    = 1'b1;
          state_d        = REQ;
        end
      end
    endcase

    if (BranchTaken) begin
      pc_d           = word_align(BranchTarget);
      misaligned_d   = (BranchTarget[1:0] != 2'b00);
      ifid_valid_d   = 1'b0;
      ifid_instr_d   = ifid_instr_q;
      ifid_pcplus4_d = ifid_pcplus4_q;
      skid_load      = 1'b0;
      skid_unload    = 1'b0;
      skid_flush     = 1'b1;
      unique case (state_q)
        REQ:  drop_d = 1'b1;
        WAIT: begin
          if (ImemRspValid) begin
            drop_d  = 1'b0;
            state_d = REQ;
          end else begin
            drop_d = 1'b1;
          end
        end
        HOLD:    state_d = REQ;
        default: ;
      endcase
    end
  end

  // A pending request keeps its address even if the PC is redirected under it.
  assign req_addr_d = (state_q == REQ && !ImemReqReady) ? req_addr_q : pc_d;

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q        <= IDLE;
      pc_q           <= RESET_PC;
      req_addr_q     <= RESET_PC;
      fetch_addr_q   <= RESET_PC;
      drop_q         <= 1'b0;
      ifid_valid_q   <= 1'b0;
      ifid_instr_q   <= '0;
      ifid_pcplus4_q <= '0;
      misaligned_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      req_addr_q     <= req_addr_d;
      fetch_addr_q   <= fetch_addr_d;
      drop_q         <= drop_d;
      ifid_valid_q   <= ifid_valid_d;
      ifid_instr_q   <= ifid_instr_d;
      ifid_pcplus4_q <= ifid_pcplus4_d;
      misaligned_q   <= misaligned_d;
    end
  end

  assign ImemReqValid     = (state_q == REQ);
  assign ImemReqAddr      = req_addr_q;
  assign IfIdValid        = ifid_valid_q;
  assign IfIdInstr        = ifid_instr_q;
  assign IfIdPcPlus4      = ifid_pcplus4_q;
  assign TargetMisaligned = misaligned_q;

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Bench for fetch_pc_stage: directed scenarios, then random backpressure and
// branches checked against an in-order instruction-stream reference model.
module tb_fetch_pc_stage;

  logic        Clk = 1'b0;
  logic        ResetN = 1'b1;
  logic        BranchTaken = 1'b0;
  logic [31:0] BranchTarget = '0;
  logic        ImemReqValid;
  logic [31:0] ImemReqAddr;
  logic        ImemReqReady = 1'b0;
  logic        ImemRspValid = 1'b0;
  logic [31:0] ImemRspData = '0;
  logic        IfIdValid;
  logic [31:0] IfIdInstr;
  logic [31:0] IfIdPcPlus4;
  logic        IfIdReady = 1'b0;
  logic        TargetMisaligned;

  // Second instance exercising the top-of-memory reset address.
  logic        w_ImemReqValid;
  logic [31:0] w_ImemReqAddr;
  logic        w_ImemRspValid = 1'b0;
  logic [31:0] w_ImemRspData = '0;
  logic        w_IfIdValid;
  logic [31:0] w_IfIdInstr;
  logic [31:0] w_IfIdPcPlus4;
  logic        w_TargetMisaligned;
  logic        w_one = 1'b1;
  logic        w_zero = 1'b0;
  logic [31:0] w_zero32 = '0;

  always #5 Clk = ~Clk;

  fetch_pc_stage #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) dut (
    .Clk(Clk), .ResetN(ResetN), .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .ImemReqValid(ImemReqValid), .ImemReqAddr(ImemReqAddr), .ImemReqReady(ImemReqReady),
    .ImemRspValid(ImemRspValid), .ImemRspData(ImemRspData),
    .IfIdValid(IfIdValid), .IfIdInstr(IfIdInstr), .IfIdPcPlus4(IfIdPcPlus4),
    .IfIdReady(IfIdReady), .TargetMisaligned(TargetMisaligned)
  );

  fetch_pc_stage #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(32'd4)) dut_wrap (
    .Clk(Clk), .ResetN(ResetN), .BranchTaken(w_zero), .BranchTarget(w_zero32),
    .ImemReqValid(w_ImemReqValid), .ImemReqAddr(w_ImemReqAddr), .ImemReqReady(w_one),
    .ImemRspValid(w_ImemRspValid), .ImemRspData(w_ImemRspData),
    .IfIdValid(w_IfIdValid), .IfIdInstr(w_IfIdInstr), .IfIdPcPlus4(w_IfIdPcPlus4),
    .IfIdReady(w_one), .TargetMisaligned(w_TargetMisaligned)
  );

  int n_asserts = 0;
  int n_fail = 0;
  int n_consumed = 0;

  // Reference model: the next instruction decode should see, plus memory responder.
  logic [31:0] exp_pc = '0;
  logic        exp_misal = 1'b0;
  logic        prev_br = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] last_acc_addr = '0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          pend_cnt = 0;
  int          lat_cfg = 1;
  logic        poison = 1'b0;

  logic [31:0] w_q[$];
  logic        w_seen = 1'b0;
  logic [31:0] w_first_pcp4 = '0;

  logic        s_req_valid, s_ifid_valid, s_misal, s_acc;
  logic [31:0] s_req_addr, s_ifid_instr, s_ifid_pcp4;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h2002_0005 ^ {a[15:0], a[31:16]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  // One clock: sample and check at the falling edge, update stimulus after the rising edge.
  task automatic cycle();
    logic        acc;
    logic        br;
    logic [31:0] tgt;
    logic        w_acc;
    @(negedge Clk);
    s_req_valid  = ImemReqValid;
    s_req_addr   = ImemReqAddr;
    s_ifid_valid = IfIdValid;
    s_ifid_instr = IfIdInstr;
    s_ifid_pcp4  = IfIdPcPlus4;
    s_misal      = TargetMisaligned;
    acc          = ImemReqValid && ImemReqReady;
    s_acc        = acc;
    br           = BranchTaken;
    tgt          = BranchTarget;
    if (ResetN) begin
      check1("misaligned_pulse", TargetMisaligned, exp_misal);
      if (prev_br) check1("ifid_flushed_by_branch", IfIdValid, 1'b0);
      if (prev_stall) begin
        check1("req_held_valid", ImemReqValid, 1'b1);
        check("req_held_addr", ImemReqAddr, prev_addr);
      end
      if (pend || ImemRspValid) check1("single_outstanding", ImemReqValid, 1'b0);
      if (IfIdValid && IfIdReady) begin
        check("stream_instr", IfIdInstr, memf(exp_pc));
        check("stream_pcplus4", IfIdPcPlus4, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
        n_consumed++;
      end
      if (br) exp_pc = {tgt[31:2], 2'b00};
      exp_misal  = br && (tgt[1:0] != 2'b00);
      prev_br    = br;
      prev_stall = ImemReqValid && !ImemReqReady;
      prev_addr  = ImemReqAddr;
      if (acc) last_acc_addr = ImemReqAddr;
      if (w_ImemReqValid) w_q.push_back(w_ImemReqAddr);
      if (w_IfIdValid && !w_seen) begin
        w_seen       = 1'b1;
        w_first_pcp4 = w_IfIdPcPlus4;
      end
    end
    w_acc = ResetN && w_ImemReqValid;
    @(posedge Clk);
    #1;
    BranchTaken  = 1'b0;
    ImemRspValid = 1'b0;
    if (acc && ResetN) begin
      pend      = 1'b1;
      pend_addr = last_acc_addr;
      pend_cnt  = (lat_cfg == 0) ? int'($urandom_range(1, 3)) : lat_cfg;
    end
    if (pend) begin
      if (pend_cnt <= 1) begin
        ImemRspValid = 1'b1;
        ImemRspData  = poison ? 32'hDEAD_BEEF : memf(pend_addr);
        poison       = 1'b0;
        pend         = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
    w_ImemRspValid = w_acc;
    w_ImemRspData  = 32'h1357_9BDF;
  endtask

  task automatic wait_acc(input string tag, output logic [31:0] addr);
    int k;
    for (k = 0; k < 40; k++) begin
      cycle();
      if (s_acc) break;
    end
    if (k == 40) check1({tag, "_timeout"}, 1'b0, 1'b1);
    addr = s_req_addr;
  endtask

  task automatic wait_ifid(input string tag);
    int k;
    for (k = 0; k < 40; k++) begin
      cycle();
      if (s_ifid_valid) break;
    end
    if (k == 40) check1({tag, "_timeout"}, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    ResetN = 1'b0;
    #1;
    check1("rst_req_valid", ImemReqValid, 1'b0);
    check("rst_req_addr", ImemReqAddr, 32'h0);
    check1("rst_ifid_valid", IfIdValid, 1'b0);
    check("rst_ifid_instr", IfIdInstr, 32'h0);
    check("rst_ifid_pcplus4", IfIdPcPlus4, 32'h0);
    check1("rst_misaligned", TargetMisaligned, 1'b0);
    check("rst_wrap_req_addr", w_ImemReqAddr, 32'hFFFF_FFFC);
    pend = 1'b0; ImemRspValid = 1'b0; BranchTaken = 1'b0; poison = 1'b0;
    prev_br = 1'b0; prev_stall = 1'b0; exp_misal = 1'b0; exp_pc = 32'h0;
    w_ImemRspValid = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    ResetN = 1'b1;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] held;

    // Reset and basic fetch
    #2;
    do_reset();
    ImemReqReady = 1'b1; IfIdReady = 1'b1; lat_cfg = 1;
    wait_acc("basic_first", a);
    check("basic_first_addr", a, 32'h0);
    wait_ifid("basic_ifid");
    check("basic_instr", s_ifid_instr, 32'h2002_0005);
    check("basic_pcplus4", s_ifid_pcp4, 32'h4);
    check1("basic_second_req_valid", s_req_valid, 1'b1);
    check("basic_second_addr", s_req_addr, 32'h4);

    // Backpressure into HOLD, then release
    IfIdReady = 1'b0;
    repeat (12) cycle();
    check1("hold_no_request", s_req_valid, 1'b0);
    check1("hold_ifid_full", s_ifid_valid, 1'b1);
    held = last_acc_addr;
    IfIdReady = 1'b1;
    wait_acc("hold_resume", a);
    check("hold_resume_addr", a, held + 32'd4);

    // Redirect while waiting; the late response must be dropped
    lat_cfg = 2;
    wait_acc("wait_redirect_setup", a);
    BranchTaken = 1'b1; BranchTarget = 32'h40; poison = 1'b1;
    cycle();
    cycle();
    check1("wait_redirect_ifid_empty", s_ifid_valid, 1'b0);
    wait_acc("wait_redirect_target", a);
    check("wait_redirect_addr", a, 32'h40);
    wait_ifid("wait_redirect_ifid");
    check("wait_redirect_pcplus4", s_ifid_pcp4, 32'h44);

    // Branch in the same cycle as a response
    wait_acc("simul_setup", a);
    cycle();
    check1("simul_rsp_present", ImemRspValid, 1'b1);
    BranchTaken = 1'b1; BranchTarget = 32'h100;
    cycle();
    wait_acc("simul_target", a);
    check("simul_addr", a, 32'h100);

    // Misaligned target
    lat_cfg = 1;
    wait_acc("misal_setup", a);
    BranchTaken = 1'b1; BranchTarget = 32'h43;
    cycle();
    cycle();
    check1("misal_pulse_high", s_misal, 1'b1);
    check("misal_req_addr", last_acc_addr, 32'h40);
    cycle();
    check1("misal_pulse_low", s_misal, 1'b0);

    // Address wrap through a branch to the last word
    BranchTaken = 1'b1; BranchTarget = 32'hFFFF_FFFC;
    cycle();
    wait_acc("wrap_first", a);
    check("wrap_first_addr", a, 32'hFFFF_FFFC);
    wait_ifid("wrap_ifid");
    check("wrap_pcplus4", s_ifid_pcp4, 32'h0);
    check("wrap_second_addr", s_req_addr, 32'h0);

    // Reset in WAIT, then a stale response after release
    lat_cfg = 3;
    wait_acc("reset_setup", a);
    #2;
    do_reset();
    ImemRspValid = 1'b1; ImemRspData = 32'hDEAD_BEEF;
    cycle();
    cycle();
    check1("stale_rsp_ignored", s_ifid_valid, 1'b0);

    // Instance with RESET_PC at the top of memory
    check("wrap_inst_first", (w_q.size() > 0) ? w_q[0] : 32'h1, 32'hFFFF_FFFC);
    check("wrap_inst_second", (w_q.size() > 1) ? w_q[1] : 32'h1, 32'h0);
    check1("wrap_inst_loaded", w_seen, 1'b1);
    check("wrap_inst_pcplus4", w_first_pcp4, 32'h0);

    // Random backpressure, latency and branches
    lat_cfg = 0;
    for (int i = 0; i < 1500; i++) begin
      ImemReqReady = ($urandom_range(0, 3) != 0);
      IfIdReady    = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 24) == 0) begin
        BranchTaken  = 1'b1;
        BranchTarget = $urandom;
      end
      cycle();
    end
    check1("random_progress", n_consumed > 100, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
